// File: rtl/proc_pkg.sv
// Shared encodings for the 4-bit processor: opcodes, ALU operations,
// sequencer states and the decoded control bundle.
package proc_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_OUT = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_JC  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;
    localparam logic [2:0] ALU_XOR  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    // Decoded control for one instruction, before EXECUTE gating
    typedef struct packed {
        logic       acc_load;
        logic [2:0] alu_op;
        logic       out_load;
        logic       jump_taken;
        logic       is_halt;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decoder: opcode plus ALU flags to control bundle.
module instr_decoder
    import proc_pkg::*;
#(
    parameter int OPC_WIDTH = 4
) (
    input  logic [OPC_WIDTH-1:0] opcode,
    input  logic                 zero_flag,
    input  logic                 carry_flag,
    output ctrl_t                ctrl
);

    // Map each opcode to its action; undefined opcodes behave as NOP but flag illegal
    always_comb begin
        ctrl = '0;
        case (opcode)
            OPC_WIDTH'(OP_NOP): ;
            OPC_WIDTH'(OP_LDI): begin ctrl.acc_load = 1'b1; ctrl.alu_op = ALU_PASS; end
            OPC_WIDTH'(OP_ADD): begin ctrl.acc_load = 1'b1; ctrl.alu_op = ALU_ADD;  end
            OPC_WIDTH'(OP_SUB): begin ctrl.acc_load = 1'b1; ctrl.alu_op = ALU_SUB;  end
            OPC_WIDTH'(OP_AND): begin ctrl.acc_load = 1'b1; ctrl.alu_op = ALU_AND;  end
            OPC_WIDTH'(OP_OR):  begin ctrl.acc_load = 1'b1; ctrl.alu_op = ALU_OR;   end
            OPC_WIDTH'(OP_XOR): begin ctrl.acc_load = 1'b1; ctrl.alu_op = ALU_XOR;  end
            OPC_WIDTH'(OP_OUT): ctrl.out_load   = 1'b1;
            OPC_WIDTH'(OP_JMP): ctrl.jump_taken = 1'b1;
            OPC_WIDTH'(OP_JZ):  ctrl.jump_taken = zero_flag;
            OPC_WIDTH'(OP_JC):  ctrl.jump_taken = carry_flag;
            OPC_WIDTH'(OP_HLT): ctrl.is_halt    = 1'b1;
            default:            ctrl.illegal    = 1'b1;
        endcase
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Fetch/decode/execute sequencer: owns the state register and the IR, and
// gates the decoded control onto one-cycle strobes during EXECUTE.
module instruction_sequencer
    import proc_pkg::*;
#(
    parameter  int WIDTH     = 4,
    parameter  int OPC_WIDTH = 4,
    localparam int INSTR_W   = OPC_WIDTH + WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               zero_flag,
    input  logic               carry_flag,
    output logic               pc_enable,
    output logic               pc_load,
    output logic [WIDTH-1:0]   pc_in,
    output logic [INSTR_W-1:0] ir_out,
    output logic [WIDTH-1:0]   imm_out,
    output logic               acc_load,
    output logic [2:0]         alu_op,
    output logic               out_load,
    output logic               illegal,
    output logic               halted,
    output logic [2:0]         state_out
);

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    ctrl_t              ctrl;
    logic               exec_active;

    instr_decoder #(
        .OPC_WIDTH (OPC_WIDTH)
    ) u_decoder (
        .opcode     (ir_q[INSTR_W-1 -: OPC_WIDTH]),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag),
        .ctrl       (ctrl)
    );

    // State and instruction registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next state: FETCH/DECODE ignore run so a started instruction always completes
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (run) state_d = ST_FETCH;
            ST_FETCH:   state_d = ST_DECODE;
            ST_DECODE:  state_d = ST_EXECUTE;
            ST_EXECUTE: begin
                if (ctrl.is_halt) state_d = ST_HALT;
                else if (run)     state_d = ST_FETCH;
                else              state_d = ST_IDLE;
            end
            ST_HALT:    state_d = ST_HALT;
            default:    state_d = ST_IDLE;
        endcase
    end

    // IR captures memory data only during FETCH
    always_comb begin
        ir_d = ir_q;
        if (state_q == ST_FETCH) ir_d = instr_in;
    end

    // Strobes exist only in EXECUTE; reset masks them in its own cycle
    always_comb begin
        exec_active = (state_q == ST_EXECUTE) && !reset;
        pc_enable   = 1'b0;
        pc_load     = 1'b0;
        pc_in       = '0;
        acc_load    = 1'b0;
        alu_op      = ALU_PASS;
        out_load    = 1'b0;
        illegal     = 1'b0;
        halted      = (state_q == ST_HALT) && !reset;
        if (exec_active) begin
            acc_load  = ctrl.acc_load;
            alu_op    = ctrl.alu_op;
            out_load  = ctrl.out_load;
            illegal   = ctrl.illegal;
            pc_load   = ctrl.jump_taken;
            pc_in     = ctrl.jump_taken ? ir_q[WIDTH-1:0] : '0;
            pc_enable = !ctrl.jump_taken && !ctrl.is_halt;
        end
    end

    assign ir_out    = ir_q;
    assign imm_out   = ir_q[WIDTH-1:0];
    assign state_out = state_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench for instruction_sequencer: an ISA-level model predicts
// the EXECUTE-cycle strobes of each fetched instruction; a monitor checks them.
module tb_instruction_sequencer;

    logic       clk = 1'b0;
    logic       reset, run, zero_flag, carry_flag;
    logic [7:0] instr_in;
    logic       pc_enable, pc_load, acc_load, out_load, illegal, halted;
    logic [3:0] pc_in, imm_out;
    logic [7:0] ir_out;
    logic [2:0] alu_op, state_out;

    instruction_sequencer #(.WIDTH(4), .OPC_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .run(run), .instr_in(instr_in),
        .zero_flag(zero_flag), .carry_flag(carry_flag),
        .pc_enable(pc_enable), .pc_load(pc_load), .pc_in(pc_in),
        .ir_out(ir_out), .imm_out(imm_out), .acc_load(acc_load),
        .alu_op(alu_op), .out_load(out_load), .illegal(illegal),
        .halted(halted), .state_out(state_out)
    );

    always #5 clk = ~clk;

    // Program memory and a PC driven by the DUT strobes, as the datapath would
    logic [7:0] mem [16];
    logic [3:0] pc;
    always @(posedge clk) begin
        if (reset)          pc <= 4'd0;
        else if (pc_load)   pc <= pc_in;
        else if (pc_enable) pc <= pc + 4'd1;
    end
    assign instr_in = mem[pc];

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic       acc_load;
        logic [2:0] alu_op;
        logic       out_load;
        logic       pc_enable;
        logic       pc_load;
        logic [3:0] pc_in;
        logic       illegal;
        logic [7:0] ir;
        logic [2:0] nxt;
        int         fcyc;
    } exp_t;

    exp_t       sbq[$];
    int         total = 0;
    int         bad = 0;
    bit         mon_en = 0;
    bit         pending = 0;
    logic [2:0] pend_state;
    logic [3:0] model_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ISA-level behaviour of one instruction; also advances the model PC
    function automatic exp_t model(input logic [7:0] ins, input logic z, input logic c,
                                   input logic r, input int fc);
        exp_t e;
        int   op;
        bit   taken;
        op = int'(ins[7:4]);
        e = '{default: '0};
        e.ir   = ins;
        e.fcyc = fc;
        if (op >= 1 && op <= 6) begin
            e.acc_load = 1'b1;
            e.alu_op   = 3'(op - 1);
        end
        e.out_load  = (op == 7);
        taken       = (op == 8) || (op == 9 && z) || (op == 10 && c);
        e.pc_load   = taken;
        e.pc_in     = taken ? ins[3:0] : 4'd0;
        e.pc_enable = !taken && (op != 15);
        e.illegal   = (op >= 11 && op <= 14);
        e.nxt       = (op == 15) ? 3'd4 : (r ? 3'd1 : 3'd0);
        if (taken)         model_pc = ins[3:0];
        else if (op != 15) model_pc = model_pc + 4'd1;
        return e;
    endfunction

    // Monitor: compare every EXECUTE cycle against the scoreboard head
    always @(negedge clk) begin
        if (mon_en) begin
            if (pending) begin
                chk("next_state", 32'(state_out), 32'(pend_state));
                pending = 0;
            end
            if (state_out == 3'd3) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_execute: got ir %0h required no instruction", ir_out);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("ir_out",    32'(ir_out),    32'(e.ir));
                    chk("imm_out",   32'(imm_out),   32'(e.ir[3:0]));
                    chk("acc_load",  32'(acc_load),  32'(e.acc_load));
                    chk("alu_op",    32'(alu_op),    32'(e.alu_op));
                    chk("out_load",  32'(out_load),  32'(e.out_load));
                    chk("pc_enable", 32'(pc_enable), 32'(e.pc_enable));
                    chk("pc_load",   32'(pc_load),   32'(e.pc_load));
                    chk("pc_in",     32'(pc_in),     32'(e.pc_in));
                    chk("illegal",   32'(illegal),   32'(e.illegal));
                    chk("latency",   32'(cyc - e.fcyc), 32'd2);
                    pending    = 1;
                    pend_state = e.nxt;
                end
            end else begin
                chk("quiet_strobes",
                    32'({pc_enable, pc_load, pc_in, acc_load, alu_op, out_load, illegal, halted}), 32'd0);
            end
        end
    end

    // Wait for a given state at a falling edge, bounded
    task automatic wait_state(input logic [2:0] st, input string name);
        bit ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (state_out == st) begin ok = 1; break; end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL %s_timeout: got state %0d required %0d", name, state_out, st);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] init_prog [8];
        init_prog = '{8'h15, 8'h23, 8'h99, 8'hC0, 8'h70, 8'hA4, 8'h00, 8'h80};
        for (int i = 0; i < 16; i++) mem[i] = (i < 8) ? init_prog[i] : 8'h00;
        reset = 1'b1; run = 1'b0; zero_flag = 1'b0; carry_flag = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_ir",    32'(ir_out),    32'd0);
        chk("rst_outs",
            32'({pc_enable, pc_load, pc_in, acc_load, alu_op, out_load, illegal, halted}), 32'd0);
        reset = 1'b0;
        model_pc = 4'd0;
        mon_en = 1;

        // Randomised program execution with random flags and run drops
        for (int n = 0; n < 300; n++) begin
            bit   ok = 0;
            logic z, c, r;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (state_out == 3'd1) begin ok = 1; break; end
                if (state_out == 3'd0) run = 1'b1;
            end
            if (!ok) begin
                total++; bad++;
                $display("FAIL fetch_timeout: got state %0d required 1", state_out);
                break;
            end
            if (n > 0 && n % 40 == 0)
                for (int i = 0; i < 16; i++)
                    mem[i] = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))};
            chk("pc_track", 32'(pc), 32'(model_pc));
            z = 1'($urandom); c = 1'($urandom);
            r = (n == 299) ? 1'b0 : ($urandom_range(0, 3) != 0);
            zero_flag = z; carry_flag = c; run = r;
            sbq.push_back(model(mem[model_pc], z, c, r, cyc));
        end
        repeat (8) @(negedge clk);
        chk("drain", 32'(sbq.size()), 32'd0);
        mon_en = 0;

        // HLT: absorbing, no PC strobe, only reset leaves it
        for (int i = 0; i < 16; i++) mem[i] = 8'hF0;
        reset = 1'b1; @(negedge clk); reset = 1'b0; run = 1'b1;
        wait_state(3'd3, "hlt_exec");
        chk("hlt_pc_strobes", 32'({pc_enable, pc_load}), 32'd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("hlt_state",  32'(state_out), 32'd4);
            chk("hlt_halted", 32'(halted),    32'd1);
            chk("hlt_quiet",  32'({pc_enable, pc_load, acc_load, out_load}), 32'd0);
        end
        reset = 1'b1; @(negedge clk);
        chk("hlt_reset_state", 32'(state_out), 32'd0);
        chk("hlt_reset_halted", 32'(halted), 32'd0);
        reset = 1'b0;

        // Reset during DECODE of ADD 3
        for (int i = 0; i < 16; i++) mem[i] = 8'h23;
        wait_state(3'd2, "add_decode");
        reset = 1'b1;
        @(negedge clk);
        chk("dec_rst_state", 32'(state_out), 32'd0);
        chk("dec_rst_strb",  32'({acc_load, pc_enable}), 32'd0);
        chk("dec_rst_ir",    32'(ir_out), 32'd0);
        reset = 1'b0;

        // Reset arriving in the EXECUTE cycle suppresses that cycle's strobes
        wait_state(3'd3, "add_exec");
        reset = 1'b1;
        #1;
        chk("exe_rst_strb", 32'({acc_load, pc_enable, pc_load, out_load}), 32'd0);
        @(negedge clk);
        chk("exe_rst_state", 32'(state_out), 32'd0);
        reset = 1'b0; run = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
